// File: rtl/alu_seq_pkg.sv
// Shared types and opcode constants for the ALU fetch/decode/execute sequencer.
// Pure declarations: no latency and no flow control.
package alu_seq_pkg;

   localparam int PC_W   = 12;
   localparam int INSN_W = 16;
   localparam int OP_W   = 8;

   localparam logic [PC_W-1:0] DEF_RESET_PC   = 12'h000;
   localparam logic [PC_W-1:0] DEF_IRQ_VECTOR = 12'h004;
   localparam logic [OP_W-1:0] DEF_HALT_OP    = 8'hFF;
   localparam logic [OP_W-1:0] DEF_RTI_OP     = 8'h7E;

   // Opcodes forwarded to the ALU occupy a contiguous range; SC/SZ are the skip ops.
   localparam logic [OP_W-1:0] ALU_OP_FIRST = 8'h71;
   localparam logic [OP_W-1:0] ALU_OP_LAST  = 8'h7D;
   localparam logic [OP_W-1:0] OP_SC        = 8'h7C;
   localparam logic [OP_W-1:0] OP_SZ        = 8'h7D;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_WB,
      ST_IRQ,
      ST_HALT
   } seq_state_e;

   typedef enum logic [2:0] {
      PC_HOLD,
      PC_INC,
      PC_SKIP,
      PC_EPC,
      PC_VEC
   } pc_sel_e;

   function automatic logic is_alu_op(input logic [OP_W-1:0] op);
      return (op >= ALU_OP_FIRST) && (op <= ALU_OP_LAST);
   endfunction

   function automatic logic is_skip_op(input logic [OP_W-1:0] op);
      return (op == OP_SC) || (op == OP_SZ);
   endfunction

endpackage

// File: rtl/seq_pc_next.sv
// Next-PC select for the sequencer (mod-4096 arithmetic, skip resolution, RTI, vector).
// Purely combinational, zero latency; no flow control.
module seq_pc_next
   import alu_seq_pkg::*;
#(
   parameter logic [PC_W-1:0] IRQ_VECTOR = DEF_IRQ_VECTOR
) (
   input  pc_sel_e         pc_sel,
   input  logic [PC_W-1:0] pc,
   input  logic [PC_W-1:0] alu_pcnew,
   input  logic [PC_W-1:0] epc,
   output logic [PC_W-1:0] pc_next,
   output logic [PC_W-1:0] pc_inc
);

   logic [PC_W-1:0] pc_inc2;

   assign pc_inc  = pc + 12'd1;
   assign pc_inc2 = pc + 12'd2;

   // alu_pcnew is stale when the skip is not taken, so only an exact pc+2 match counts.
   always_comb begin
      pc_next = pc;
      case (pc_sel)
         PC_INC:  pc_next = pc_inc;
         PC_SKIP: pc_next = (alu_pcnew == pc_inc2) ? pc_inc2 : pc_inc;
         PC_EPC:  pc_next = epc;
         PC_VEC:  pc_next = IRQ_VECTOR;
         default: pc_next = pc;
      endcase
   end

endmodule

// File: rtl/alu_sequencer.sv
// Fetch/decode/execute controller owning the PC; 4 cycles per ALU instruction with zero-wait imem.
// Holds imem_req until imem_ack (waits indefinitely); start is ignored while busy.
module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC   = DEF_RESET_PC,
   parameter logic [PC_W-1:0] IRQ_VECTOR = DEF_IRQ_VECTOR,
   parameter logic [OP_W-1:0] HALT_OP    = DEF_HALT_OP,
   parameter logic [OP_W-1:0] RTI_OP     = DEF_RTI_OP
) (
   input  logic              pixel_clock,
   input  logic              rst,
   input  logic              start,
   output logic              imem_req,
   output logic [PC_W-1:0]   imem_addr,
   input  logic              imem_ack,
   input  logic [INSN_W-1:0] imem_data,
   output logic [OP_W-1:0]   alu_op,
   output logic [PC_W-1:0]   alu_pc,
   output logic              alu_run,
   input  logic [PC_W-1:0]   alu_pcnew,
   input  logic              alu_ion,
   input  logic              irq,
   output logic              irq_ack,
   output logic              busy,
   output logic              halted
);

   seq_state_e        state_q, state_d;
   logic [PC_W-1:0]   pc_q, epc_q, alu_pc_q;
   logic [INSN_W-1:0] ir_q;
   logic [OP_W-1:0]   alu_op_q;
   logic              in_irq_q;

   pc_sel_e           pc_sel;
   logic [PC_W-1:0]   pc_next, pc_inc;
   logic [OP_W-1:0]   opcode;
   logic              ir_load, alu_load, epc_load, in_irq_set, in_irq_clr;
   logic              irq_take;
   logic              ir_lo_unused;

   assign opcode       = ir_q[15:8];
   assign ir_lo_unused = ^ir_q[7:0];
   assign irq_take     = irq & alu_ion & ~in_irq_q;

   seq_pc_next #(
      .IRQ_VECTOR (IRQ_VECTOR)
   ) u_pc_next (
      .pc_sel    (pc_sel),
      .pc        (pc_q),
      .alu_pcnew (alu_pcnew),
      .epc       (epc_q),
      .pc_next   (pc_next),
      .pc_inc    (pc_inc)
   );

   always_comb begin
      state_d    = state_q;
      pc_sel     = PC_HOLD;
      ir_load    = 1'b0;
      alu_load   = 1'b0;
      epc_load   = 1'b0;
      in_irq_set = 1'b0;
      in_irq_clr = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_FETCH;
         end
         ST_HALT: begin
            if (start) begin
               pc_sel  = PC_INC;
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (imem_ack) begin
               ir_load = 1'b1;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            if (opcode == HALT_OP) begin
               state_d = ST_HALT;
            end else if (opcode == RTI_OP) begin
               // RTI goes straight back to fetch; no interrupt check on this path.
               pc_sel     = PC_EPC;
               in_irq_clr = 1'b1;
               state_d    = ST_FETCH;
            end else if (is_alu_op(opcode)) begin
               alu_load = 1'b1;
               state_d  = ST_EXEC;
            end else begin
               pc_sel  = PC_INC;
               state_d = irq_take ? ST_IRQ : ST_FETCH;
            end
         end
         ST_EXEC: begin
            state_d = ST_WB;
         end
         ST_WB: begin
            pc_sel  = is_skip_op(opcode) ? PC_SKIP : PC_INC;
            state_d = irq_take ? ST_IRQ : ST_FETCH;
         end
         ST_IRQ: begin
            // pc already holds the post-instruction value here, which is the return address.
            epc_load   = 1'b1;
            in_irq_set = 1'b1;
            pc_sel     = PC_VEC;
            state_d    = ST_FETCH;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge pixel_clock or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         pc_q     <= RESET_PC;
         ir_q     <= '0;
         epc_q    <= '0;
         in_irq_q <= 1'b0;
         alu_op_q <= '0;
         alu_pc_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_next;
         if (ir_load)  ir_q <= imem_data;
         if (epc_load) epc_q <= pc_q;
         if (in_irq_set)      in_irq_q <= 1'b1;
         else if (in_irq_clr) in_irq_q <= 1'b0;
         if (alu_load) begin
            alu_op_q <= opcode;
            alu_pc_q <= pc_inc;
         end
      end
   end

   assign imem_req  = (state_q == ST_FETCH);
   assign imem_addr = imem_req ? pc_q : '0;
   assign alu_run   = (state_q == ST_EXEC);
   assign alu_op    = alu_op_q;
   assign alu_pc    = alu_pc_q;
   assign irq_ack   = (state_q == ST_IRQ);
   assign halted    = (state_q == ST_HALT);
   assign busy      = (state_q != ST_IDLE) && (state_q != ST_HALT);

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: fetch timing, skips, interrupts, halt/wrap, reset mid-fetch.
module tb_alu_sequencer;

   logic        pixel_clock = 1'b0;
   logic        rst, start, imem_ack, alu_ion, irq;
   logic [15:0] imem_data;
   logic [11:0] alu_pcnew;
   logic        imem_req, alu_run, irq_ack, busy, halted;
   logic [11:0] imem_addr, alu_pc;
   logic [7:0]  alu_op;

   int total = 0;
   int bad   = 0;

   alu_sequencer dut (
      .pixel_clock (pixel_clock),
      .rst         (rst),
      .start       (start),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_data   (imem_data),
      .alu_op      (alu_op),
      .alu_pc      (alu_pc),
      .alu_run     (alu_run),
      .alu_pcnew   (alu_pcnew),
      .alu_ion     (alu_ion),
      .irq         (irq),
      .irq_ack     (irq_ack),
      .busy        (busy),
      .halted      (halted)
   );

   always #5 pixel_clock = ~pixel_clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for a fetch, checks its address, holds ack off wait_n cycles, then acks.
   // Returns at the falling edge where the sequencer is in DECODE.
   task automatic fetch(input logic [11:0] addr, input logic [15:0] data, input int wait_n);
      int n = 0;
      while (imem_req !== 1'b1 && n < 20) begin
         @(negedge pixel_clock);
         n++;
      end
      chk("fetch_req", {31'd0, imem_req}, 32'd1);
      chk("fetch_addr", {20'd0, imem_addr}, {20'd0, addr});
      for (int i = 0; i < wait_n; i++) begin
         @(negedge pixel_clock);
         chk("wait_req", {31'd0, imem_req}, 32'd1);
         chk("wait_addr", {20'd0, imem_addr}, {20'd0, addr});
      end
      imem_ack  = 1'b1;
      imem_data = data;
      @(negedge pixel_clock);
      imem_ack  = 1'b0;
      imem_data = 16'h0000;
   endtask

   // Runs one ALU instruction; returns at the falling edge where the sequencer is in WB.
   task automatic alu_instr(input logic [11:0] pc_now, input logic [7:0] op,
                            input logic [11:0] pcnew, input logic irq_v, input int wait_n);
      logic [11:0] exp_pc;
      exp_pc = pc_now + 12'd1;
      fetch(pc_now, {op, 8'h00}, wait_n);
      @(negedge pixel_clock);
      chk("exec_run", {31'd0, alu_run}, 32'd1);
      chk("exec_op", {24'd0, alu_op}, {24'd0, op});
      chk("exec_pc", {20'd0, alu_pc}, {20'd0, exp_pc});
      alu_pcnew = pcnew;
      irq       = irq_v;
      @(negedge pixel_clock);
      chk("wb_run", {31'd0, alu_run}, 32'd0);
   endtask

   initial begin
      logic [11:0] a;
      rst = 1'b1; start = 1'b0; imem_ack = 1'b0; imem_data = 16'h0000;
      alu_pcnew = 12'h000; alu_ion = 1'b0; irq = 1'b0;
      repeat (2) @(negedge pixel_clock);
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_addr", {20'd0, imem_addr}, 32'd0);
      chk("rst_run", {31'd0, alu_run}, 32'd0);
      chk("rst_op", {24'd0, alu_op}, 32'd0);
      chk("rst_alupc", {20'd0, alu_pc}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_halted", {31'd0, halted}, 32'd0);
      chk("rst_irqack", {31'd0, irq_ack}, 32'd0);
      rst = 1'b0;

      // Cycle 0: start in IDLE; cycle 1 FETCH with zero-wait ack; cycle 3 EXEC.
      @(negedge pixel_clock); start = 1'b1;
      @(negedge pixel_clock); start = 1'b0;
      chk("c1_req", {31'd0, imem_req}, 32'd1);
      chk("c1_addr", {20'd0, imem_addr}, 32'h000);
      chk("c1_busy", {31'd0, busy}, 32'd1);
      imem_ack = 1'b1; imem_data = 16'h7100;
      @(negedge pixel_clock); imem_ack = 1'b0;
      chk("c2_run", {31'd0, alu_run}, 32'd0);
      @(negedge pixel_clock);
      chk("c3_run", {31'd0, alu_run}, 32'd1);
      chk("c3_op", {24'd0, alu_op}, 32'h71);
      chk("c3_alupc", {20'd0, alu_pc}, 32'h001);
      @(negedge pixel_clock);
      chk("c4_run", {31'd0, alu_run}, 32'd0);
      chk("c4_op_hold", {24'd0, alu_op}, 32'h71);
      @(negedge pixel_clock);
      chk("after_wb_pc", {20'd0, dut.pc_q}, 32'h001);

      // NOPs walk the PC up to 0x010.
      for (int i = 1; i < 16; i++) begin
         a = 12'(i);
         fetch(a, 16'h0000, 0);
      end

      // Skips: taken, stale pcnew, SC taken.
      alu_instr(12'h010, 8'h7D, 12'h012, 1'b0, 0);
      alu_instr(12'h012, 8'h7D, 12'h3AB, 1'b0, 0);
      alu_instr(12'h013, 8'h7C, 12'h015, 1'b0, 0);
      for (int i = 12'h015; i < 12'h020; i++) begin
         a = 12'(i);
         fetch(a, 16'h0000, 0);
      end

      // Interrupt taken after ADD at 0x020.
      alu_ion = 1'b1;
      alu_instr(12'h020, 8'h71, 12'h000, 1'b1, 0);
      @(negedge pixel_clock);
      chk("irq_ack_pulse", {31'd0, irq_ack}, 32'd1);
      chk("irq_busy", {31'd0, busy}, 32'd1);
      @(negedge pixel_clock);
      chk("irq_ack_drop", {31'd0, irq_ack}, 32'd0);
      chk("irq_epc", {20'd0, dut.epc_q}, 32'h021);

      // Nested request is blocked until RTI.
      alu_instr(12'h004, 8'h71, 12'h000, 1'b1, 0);
      @(negedge pixel_clock);
      chk("nested_blocked", {31'd0, irq_ack}, 32'd0);
      fetch(12'h005, 16'h7E00, 0);
      // RTI skips the interrupt check; the NOP after it takes the still-pending irq.
      fetch(12'h021, 16'h0000, 0);
      @(negedge pixel_clock);
      chk("nop_irq_ack", {31'd0, irq_ack}, 32'd1);
      @(negedge pixel_clock);
      chk("nop_irq_epc", {20'd0, dut.epc_q}, 32'h022);
      irq = 1'b0;
      fetch(12'h004, 16'h7E00, 0);

      for (int i = 12'h022; i < 12'hFFF; i++) begin
         a = 12'(i);
         fetch(a, 16'h0000, 0);
      end

      // HALT at the top of memory, then restart wraps to 0x000.
      fetch(12'hFFF, 16'hFF00, 0);
      @(negedge pixel_clock);
      chk("halt_halted", {31'd0, halted}, 32'd1);
      chk("halt_busy", {31'd0, busy}, 32'd0);
      chk("halt_req", {31'd0, imem_req}, 32'd0);
      repeat (2) @(negedge pixel_clock);
      chk("halt_stay", {31'd0, halted}, 32'd1);
      start = 1'b1;
      @(negedge pixel_clock); start = 1'b0;
      chk("restart_halted", {31'd0, halted}, 32'd0);
      alu_instr(12'h000, 8'h72, 12'h000, 1'b0, 5);

      // Reset in the middle of a stalled fetch; a late ack must be ignored.
      @(negedge pixel_clock);
      chk("mid_req", {31'd0, imem_req}, 32'd1);
      chk("mid_addr", {20'd0, imem_addr}, 32'h001);
      @(negedge pixel_clock);
      rst = 1'b1;
      #1;
      chk("arst_req", {31'd0, imem_req}, 32'd0);
      chk("arst_pc", {20'd0, dut.pc_q}, 32'h000);
      chk("arst_op", {24'd0, alu_op}, 32'h00);
      chk("arst_busy", {31'd0, busy}, 32'd0);
      @(negedge pixel_clock);
      rst = 1'b0;
      imem_ack = 1'b1; imem_data = 16'h7100;
      @(negedge pixel_clock);
      imem_ack = 1'b0; imem_data = 16'h0000;
      chk("stray_busy", {31'd0, busy}, 32'd0);
      chk("stray_req", {31'd0, imem_req}, 32'd0);
      chk("stray_ir", {16'd0, dut.ir_q}, 32'h0000);
      start = 1'b1;
      @(negedge pixel_clock); start = 1'b0;
      alu_instr(12'h000, 8'h73, 12'h000, 1'b0, 0);
      @(negedge pixel_clock);
      chk("final_addr", {20'd0, imem_addr}, 32'h001);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
